cla_pipe_adder32: RTL and testbench

CLA_PIPE_ADDER32 -- requirements
Module: cla_pipe_adder32

---
 rtl/cla_pipe_adder32.sv | 132 +++++++++++++
 tb/tb_cla_pipe_adder32.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder32.sv
// Two-stage pipelined 32-bit carry-lookahead adder with valid/ready handshakes.
// S1 holds bit and group propagate/generate; S2 holds the registered sum, cout and ovf.
module cla_pipe_adder32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  // Carries into positions 0..3 of a 4-wide lookahead unit, each a flat sum of products.
  function automatic logic [3:0] lookahead4(input logic [3:0] p, input logic [3:0] g,
                                            input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Block propagate/generate of four adjacent positions, returned as {P, G}.
  function automatic logic [1:0] block_pg(input logic [3:0] p, input logic [3:0] g);
    logic bp;
    logic bg;
    bp = &p;
    bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {bp, bg};
  endfunction

  logic        s1_valid;
  logic        s1_cin;
  logic [31:0] s1_p;
  logic [31:0] s1_g;
  logic [7:0]  s1_gp;
  logic [7:0]  s1_gg;

  logic [31:0] in_p;
  logic [31:0] in_g;
  logic [7:0]  in_gp;
  logic [7:0]  in_gg;

  logic        s2_free;
  logic        accept;
  logic        advance;

  logic [1:0]  lo_pg;
  logic [1:0]  hi_pg;
  logic        c_mid;
  logic        c_out;
  logic [7:0]  group_c;
  logic [31:0] bit_c;
  logic [31:0] next_sum;
  logic        next_ovf;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_free;

  always_comb begin
    in_p  = a ^ b;
    in_g  = a & b;
    in_gp = '0;
    in_gg = '0;
    for (int k = 0; k < 8; k++) begin
      {in_gp[k], in_gg[k]} = block_pg(in_p[4*k +: 4], in_g[4*k +: 4]);
    end
  end

  // Second level: two 4-group units, joined by a top combine that produces the
  // carry into group 4 and the final carry-out directly from cin.
  always_comb begin
    lo_pg   = block_pg(s1_gp[3:0], s1_gg[3:0]);
    hi_pg   = block_pg(s1_gp[7:4], s1_gg[7:4]);
    c_mid   = lo_pg[0] | (lo_pg[1] & s1_cin);
    c_out   = hi_pg[0] | (hi_pg[1] & lo_pg[0]) | (hi_pg[1] & lo_pg[1] & s1_cin);
    group_c = {lookahead4(s1_gp[7:4], s1_gg[7:4], c_mid),
               lookahead4(s1_gp[3:0], s1_gg[3:0], s1_cin)};
    bit_c   = '0;
    for (int k = 0; k < 8; k++) begin
      bit_c[4*k +: 4] = lookahead4(s1_p[4*k +: 4], s1_g[4*k +: 4], group_c[k]);
    end
    next_sum = s1_p ^ bit_c;
    next_ovf = bit_c[31] ^ c_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cin   <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_cin   <= cin;
      s1_p     <= in_p;
      s1_g     <= in_g;
      s1_gp    <= in_gp;
      s1_gg    <= in_gg;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Result data only changes on a load, so it stays put while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      sum       <= next_sum;
      cout      <= c_out;
      ovf       <= next_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder32.sv
// Self-checking bench for cla_pipe_adder32: directed corner cases, then random
// traffic scored against a 33-bit arithmetic model held in a queue.
module tb_cla_pipe_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  logic [33:0] expected_q[$];

  always #5 clk = ~clk;

  cla_pipe_adder32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference result packed as {ovf, cout, sum}; overflow from operand/result signs.
  function automatic logic [33:0] reference(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci);
    logic [32:0] total;
    logic        v;
    total = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    v = (x[31] == y[31]) && (total[31] != x[31]);
    return {v, total[32], total[31:0]};
  endfunction

  // Drive one cycle's inputs at the falling edge and score the handshakes that the
  // following rising edge will commit.
  task automatic applyStimulus(input logic iv, input logic [31:0] x, input logic [31:0] y,
                               input logic ci, input logic ordy);
    logic [33:0] exp_val;
    @(negedge clk);
    in_valid  = iv;
    a         = x;
    b         = y;
    cin       = ci;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (expected_q.size() == 0) begin
        checkOutput("spurious_result", 64'(out_valid), 64'd0);
      end else begin
        exp_val = expected_q.pop_front();
        checkOutput("random_result", 64'({ovf, cout, sum}), 64'(exp_val));
      end
    end
    if (in_valid && in_ready) expected_q.push_back(reference(x, y, ci));
  endtask

  // Accept one op on an empty pipe and confirm it appears after the second edge.
  task automatic directedOp(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic ci, input logic [33:0] exp_val);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; cin = ci; out_ready = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput({tag, "_not_yet"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_result"}, 64'({ovf, cout, sum}), 64'(exp_val));
  endtask

  initial begin
    int accepted;
    int seen;
    int drain_cycles;
    logic [31:0] held_sum;

    rst = 1'b1; in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111;
    cin = 1'b1; out_ready = 1'b0;

    // Reset state, with inputs active to show they are ignored.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'({ovf, cout, sum}), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    directedOp("all_groups_carry", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
    directedOp("pos_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    directedOp("neg_overflow", 32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
    repeat (2) @(negedge clk);

    // Back-to-back 1+2, 3+4, 5+6: valid for three straight cycles.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (c < 3); a = 32'(2*c + 1); b = 32'(2*c + 2); cin = 1'b0; out_ready = 1'b1;
      #1;
      checkOutput("b2b_valid", 64'(out_valid), 64'((c >= 2 && c <= 4) ? 1 : 0));
      if (c >= 2 && c <= 4) checkOutput("b2b_sum", 64'(sum), 64'(4*c - 5));
    end

    // Backpressure: only two ops fit, output holds still.
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'(100 + accepted); b = 32'(accepted); cin = 1'b0; out_ready = 1'b0;
      #1;
      if (c == 3) held_sum = sum;
      if (in_ready) accepted++;
    end
    checkOutput("bp_accepted", 64'(accepted), 64'd2);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_stable", 64'(sum), 64'(held_sum));
    checkOutput("bp_sum", 64'(sum), 64'd100);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checkOutput("drain_first", 64'({out_valid, sum}), {31'd0, 1'b1, 32'd100});
    @(negedge clk);
    #1;
    checkOutput("drain_second", 64'({out_valid, sum}), {31'd0, 1'b1, 32'd102});
    @(negedge clk);
    #1;
    checkOutput("drain_empty", 64'(out_valid), 64'd0);
    checkOutput("drain_in_ready", 64'(in_ready), 64'd1);

    // Reset with two ops in flight discards both.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'hDEAD_0000; b = 32'(c); cin = 1'b0; out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_sum", 64'(sum), 64'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_result", 64'(seen), 64'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
                    1'($urandom_range(0, 3) != 0));
    end
    drain_cycles = 0;
    while (expected_q.size() != 0 && drain_cycles < 20) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      drain_cycles++;
    end
    checkOutput("queue_drained", 64'(expected_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
